// File: rtl/fane_dot_acc_if.sv
// fane_dot_acc_if: beat input and FP8 result output bundle for the dot-product accumulator
interface fane_dot_acc_if #(parameter int LANES = 4);
  logic in_valid, in_ready, in_last;
  logic [8*LANES-1:0] in_a, in_b;
  logic [7:0] in_sum;
  logic out_valid, out_ready, out_sat;
  logic [7:0] out_data;
  modport master(output in_valid, in_a, in_b, in_sum, in_last, out_ready,
                 input in_ready, out_valid, out_data, out_sat);
  modport slave(input in_valid, in_a, in_b, in_sum, in_last, out_ready,
                output in_ready, out_valid, out_data, out_sat);
endinterface

// File: rtl/fane_dot_acc.sv
// fane_dot_acc: LANES-wide FP8 dot product, exact fixed-point group accumulation, truncating saturating FP8 result
module fane_dot_acc #(
  parameter int EXP_WIDTH = 4,
  parameter int MANT_WIDTH = 3,
  parameter int LANES = 4,
  parameter int ACC_GUARD = 8
) (
  input logic clk,
  input logic rst,
  fane_dot_acc_if.slave bus
);
  localparam int E = EXP_WIDTH;
  localparam int M = MANT_WIDTH;
  localparam int BIAS = 2**(E-1) - 1;
  localparam int EMAX = 2**E - 1;
  localparam int LG = $clog2(LANES);
  localparam int PROD_W = 2*M + 2 + 2*(2**E - 2);
  localparam int SUM_W = M + 1 + EMAX + BIAS + M - 2;
  localparam int LS_W = PROD_W + 1 + LG;
  localparam int ACC_W = 1 + PROD_W + LG + ACC_GUARD;
  localparam int NORM_P = 2*M + BIAS - 1;
  localparam int PW = $clog2(ACC_W) + 1;
  localparam logic signed [ACC_W:0] CMAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MAXV = ACC_W'(2**(M+1) - 1) << (EMAX + BIAS + M - 2);

  function automatic logic [M:0] sig_of(input logic [6:0] x);
    return {|x[6:M], x[M-1:0]};
  endfunction

  function automatic logic [E-1:0] eff_of(input logic [6:0] x);
    return (x[6:M] == '0) ? E'(1) : x[6:M];
  endfunction

  function automatic logic signed [PROD_W:0] prod_of(input logic [7:0] a, input logic [7:0] b);
    logic [PROD_W-1:0] m;
    m = (PROD_W'(sig_of(a[6:0])) * PROD_W'(sig_of(b[6:0]))) << (int'(eff_of(a[6:0])) + int'(eff_of(b[6:0])) - 2);
    return (a[7] ^ b[7]) ? -$signed({1'b0, m}) : $signed({1'b0, m});
  endfunction

  function automatic logic signed [SUM_W:0] fix_of(input logic [7:0] s);
    logic [SUM_W-1:0] m;
    m = SUM_W'(sig_of(s[6:0])) << (int'(eff_of(s[6:0])) + BIAS + M - 2);
    return s[7] ? -$signed({1'b0, m}) : $signed({1'b0, m});
  endfunction

  logic w_stall, r_first;
  logic r1_v, r1_first, r1_last, r2_v, r2_first, r2_last, r3_v, r3_last, r4_v, r4_sat;
  logic signed [PROD_W:0] w_prod [LANES];
  logic signed [PROD_W:0] r1_prod [LANES];
  logic signed [SUM_W:0] r1_sum, r2_sum;
  logic signed [LS_W-1:0] w_lsum, r2_lsum;
  logic signed [ACC_W:0] w_raw;
  logic signed [ACC_W-1:0] w_acc, r_acc;
  logic w_ovf, r_clamp, w_csat;
  logic [ACC_W-1:0] w_mag;
  logic [PW-1:0] w_pos;
  logic [M-1:0] w_mant;
  logic [7:0] w_fp, r4_data, r_out_data;
  logic r_out_valid, r_out_sat;

  assign w_stall = r_out_valid && !bus.out_ready;
  assign bus.in_ready = !w_stall;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data = r_out_data;
  assign bus.out_sat = r_out_sat;

  always_comb begin
    for (int k = 0; k < LANES; k++) w_prod[k] = prod_of(bus.in_a[8*k +: 8], bus.in_b[8*k +: 8]);
  end

  always_comb begin
    w_lsum = '0;
    for (int k = 0; k < LANES; k++) w_lsum = w_lsum + LS_W'(r1_prod[k]);
  end

  // Clamp symmetrically so the magnitude always fits ACC_W-1 bits for conversion
  always_comb begin
    w_raw = (r2_first ? (ACC_W+1)'(r2_sum) : (ACC_W+1)'(r_acc)) + (ACC_W+1)'(r2_lsum);
    w_ovf = (w_raw > CMAX) || (w_raw < -CMAX);
    w_acc = (w_raw > CMAX) ? ACC_W'(CMAX) : (w_raw < -CMAX) ? ACC_W'(-CMAX) : ACC_W'(w_raw);
  end

  always_comb begin
    w_mag = r_acc[ACC_W-1] ? -r_acc : r_acc;
    w_pos = '0;
    for (int k = 0; k < ACC_W; k++) if (w_mag[k]) w_pos = PW'(k);
    w_csat = w_mag > MAXV;
    w_mant = M'(w_mag >> ((w_pos < PW'(NORM_P)) ? PW'(BIAS + M - 1) : w_pos - PW'(M)));
    w_fp = {r_acc[ACC_W-1], w_csat ? 7'h7f :
            (w_pos < PW'(NORM_P)) ? {E'(0), w_mant} : {E'(int'(w_pos) - NORM_P + 1), w_mant}};
  end

  always_ff @(posedge clk)
    if (rst) begin
      r_first <= 1'b1;
      {r1_v, r1_first, r1_last, r2_v, r2_first, r2_last, r3_v, r3_last, r4_v} <= '0;
      r_acc <= '0;
      r_clamp <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data <= 8'h00;
      r_out_sat <= 1'b0;
    end else if (!w_stall) begin
      if (bus.in_valid) r_first <= bus.in_last;
      r1_v <= bus.in_valid;
      r1_first <= r_first;
      r1_last <= bus.in_last;
      {r2_v, r2_first, r2_last} <= {r1_v, r1_first, r1_last};
      {r3_v, r3_last} <= {r2_v, r2_last};
      if (r2_v && !(r_clamp && !r2_first)) begin
        r_acc <= w_acc;
        r_clamp <= w_ovf;
      end
      r4_v <= r3_v && r3_last;
      r_out_valid <= r4_v;
      if (r4_v) begin
        r_out_data <= r4_data;
        r_out_sat <= r4_sat;
      end
    end

  always_ff @(posedge clk)
    if (!w_stall) begin
      r1_prod <= w_prod;
      r1_sum <= fix_of(bus.in_sum);
      r2_lsum <= w_lsum;
      r2_sum <= r1_sum;
      r4_data <= w_fp;
      r4_sat <= w_csat || r_clamp;
    end
endmodule

// File: tb/tb_fane_dot_acc.sv
// tb_fane_dot_acc: directed vectors with a result scoreboard for the FP8 dot-product accumulator
module tb_fane_dot_acc;
  localparam int L = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tot = 0;
  int n_pass = 0;
  logic [8:0] exp_q[$];
  logic [8:0] held;
  logic [7:0] bp_sum [8] = '{8'h00, 8'h38, 8'h40, 8'h44, 8'h48, 8'h4c, 8'h50, 8'hc0};
  logic [7:0] bp_exp [8] = '{8'h48, 8'h4a, 8'h4c, 8'h4e, 8'h50, 8'h52, 8'h54, 8'h40};

  always #5 clk = ~clk;

  fane_dot_acc_if #(.LANES(L)) bus();
  fane_dot_acc_if #(.LANES(L)) f2();
  fane_dot_acc_if #(.LANES(L)) f3();
  fane_dot_acc_if #(.LANES(L)) f5();

  fane_dot_acc #(.EXP_WIDTH(4), .MANT_WIDTH(3), .LANES(L), .ACC_GUARD(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  fane_dot_acc #(.EXP_WIDTH(2), .MANT_WIDTH(5), .LANES(L), .ACC_GUARD(8)) d2 (.clk(clk), .rst(rst), .bus(f2.slave));
  fane_dot_acc #(.EXP_WIDTH(3), .MANT_WIDTH(4), .LANES(L), .ACC_GUARD(8)) d3 (.clk(clk), .rst(rst), .bus(f3.slave));
  fane_dot_acc #(.EXP_WIDTH(5), .MANT_WIDTH(2), .LANES(L), .ACC_GUARD(8)) d5 (.clk(clk), .rst(rst), .bus(f5.slave));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic logic [8*L-1:0] rep(input logic [7:0] x);
    return {L{x}};
  endfunction

  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL spurious_out: got %03h, required no result", {bus.out_sat, bus.out_data});
      end else check("result", 32'({bus.out_sat, bus.out_data}), 32'(exp_q.pop_front()));
    end

  task automatic beat(input logic [8*L-1:0] a, input logic [8*L-1:0] b, input logic [7:0] s, input logic last);
    logic rdy;
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_sum = s;
    bus.in_last = last;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      n_tot++;
      $display("FAIL accept_timeout: in_ready 0, required 1");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic issue(input logic [8*L-1:0] a, input logic [8*L-1:0] b, input logic [7:0] s,
                       input logic last, input logic [8:0] e);
    if (last) exp_q.push_back(e);
    beat(a, b, s, last);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    n_tot++;
    if (exp_q.size() == 0) n_pass++;
    else begin
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    {bus.in_valid, bus.in_last, f2.in_valid, f2.in_last, f3.in_valid, f3.in_last, f5.in_valid, f5.in_last} = '0;
    {bus.in_a, bus.in_b, f2.in_a, f2.in_b, f3.in_a, f3.in_b, f5.in_a, f5.in_b} = '0;
    {bus.in_sum, f2.in_sum, f3.in_sum, f5.in_sum} = '0;
    bus.out_ready = 1'b1;
    {f2.out_ready, f3.out_ready, f5.out_ready} = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_sat", bus.out_sat, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    issue(rep(8'h38), rep(8'h38), 8'h00, 1'b1, 9'h048);
    repeat (3) @(posedge clk);
    #1 check("latency_early", bus.out_valid, 0);
    @(posedge clk);
    #1 check("latency_t4", bus.out_valid, 1);
    drain();
    issue(rep(8'h38), rep(8'h38), 8'h40, 1'b1, 9'h04c);
    issue(rep(8'h38), rep(8'h38), 8'h00, 1'b0, 9'h000);
    issue(rep(8'h38), rep(8'h38), 8'h40, 1'b0, 9'h000);
    issue(rep(8'h38), rep(8'h38), 8'h40, 1'b1, 9'h054);
    issue({8'hb8, 8'hb8, 8'h38, 8'h38}, rep(8'h38), 8'h00, 1'b1, 9'h000);
    issue({24'h0, 8'h39}, {24'h0, 8'h39}, 8'h00, 1'b1, 9'h03a);
    issue(rep(8'h7f), rep(8'h7f), 8'h00, 1'b1, 9'h17f);
    issue(rep(8'hff), rep(8'h7f), 8'h00, 1'b1, 9'h1ff);
    drain();
    fork
      for (int k = 0; k < 8; k++) issue(rep(8'h38), rep(8'h38), bp_sum[k], 1'b1, {1'b0, bp_exp[k]});
      begin
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        held = {bus.out_sat, bus.out_data};
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_in_ready_low", bus.in_ready, 0);
        repeat (4) begin
          @(negedge clk);
          check("bp_in_ready_low", bus.in_ready, 0);
          check("bp_data_stable", 32'({bus.out_sat, bus.out_data}), 32'(held));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_high", bus.in_ready, 1);
      end
    join
    drain();
    issue(rep(8'h38), rep(8'h38), 8'h00, 1'b0, 9'h000);
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_mid_no_out", bus.out_valid, 0);
    @(posedge clk);
    #1;
    issue(rep(8'h38), rep(8'h38), 8'h00, 1'b1, 9'h048);
    drain();
    f2.in_a = rep(8'h20);
    f2.in_b = rep(8'h20);
    f3.in_a = rep(8'h30);
    f3.in_b = rep(8'h30);
    f5.in_a = rep(8'h3c);
    f5.in_b = rep(8'h3c);
    {f2.in_valid, f2.in_last, f3.in_valid, f3.in_last, f5.in_valid, f5.in_last} = '1;
    @(posedge clk);
    #1 {f2.in_valid, f3.in_valid, f5.in_valid} = '0;
    repeat (6) @(negedge clk);
    check("e2m5_valid", f2.out_valid, 1);
    check("e2m5_result", 32'({f2.out_sat, f2.out_data}), 32'h060);
    check("e3m4_valid", f3.out_valid, 1);
    check("e3m4_result", 32'({f3.out_sat, f3.out_data}), 32'h050);
    check("e5m2_valid", f5.out_valid, 1);
    check("e5m2_result", 32'({f5.out_sat, f5.out_data}), 32'h044);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
